// File: rtl/mux_rr.sv
// mux_rr: N-channel W-bit registered mux with round-robin arbitration.
// Optional MUX_FORCE_SEL_EN adds force_en/force_sel channel override.
module mux_rr #(
   parameter int N = 4,
   parameter int W = 8,
   localparam int SELW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   output logic [N-1:0]      in_ready,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_sel,
   output logic              out_valid,
   input  logic              out_ready
`ifdef MUX_FORCE_SEL_EN
   ,
   input  logic              force_en,
   input  logic [SELW-1:0]   force_sel
`endif
);

   logic [SELW-1:0] ptr;
   logic [SELW-1:0] gnt;
   logic            gnt_vld;
   logic            load;

   assign load = !out_valid || out_ready;

   // Pick the first requester at or after ptr, wrapping at N-1.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!gnt_vld && in_valid[j]) begin
            gnt_vld = 1'b1;
            gnt     = SELW'(j);
         end
      end
`ifdef MUX_FORCE_SEL_EN
      if (force_en) begin
         gnt     = force_sel;
         gnt_vld = 1'b0;
         if (int'(force_sel) < N)
            gnt_vld = in_valid[force_sel];
      end
`endif
   end

   // Accept only the granted channel, and only when the output can load.
   always_comb begin
      in_ready = '0;
      if (!rst && load && gnt_vld)
         in_ready[gnt] = 1'b1;
   end

   // Output register and arbiter pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (gnt_vld) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt)*W +: W];
            out_sel   <= gnt;
            ptr       <= (int'(gnt) == N-1) ? '0 : gnt + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
